// File: rtl/ramb_pkg.sv
// Shared definitions for the parametrised block-RAM family: write-mode codes and
// the lane-merge helper used to combine old and new words under a per-bit mask.
package ramb_pkg;

  localparam int unsigned WM_WRITE_FIRST = 0;
  localparam int unsigned WM_READ_FIRST  = 1;
  localparam int unsigned WM_NO_CHANGE   = 2;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int unsigned MaxWidth = 1024;

  function automatic logic [MaxWidth-1:0] lane_merge(
    input logic [MaxWidth-1:0] old_word,
    input logic [MaxWidth-1:0] new_word,
    input logic [MaxWidth-1:0] bit_mask
  );
    return (old_word & ~bit_mask) | (new_word & bit_mask);
  endfunction

endpackage

// File: rtl/ramb_sp_oreg.sv
// Optional pipelined output register: loads on regce_i, synchronous reset to SRVAL
// also gated by regce_i.
module ramb_sp_oreg #(
  parameter int unsigned           DATA_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] SRVAL      = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  regce_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] q_q = SRVAL;

  always_ff @(posedge clk_i) begin
    if (regce_i) begin
      if (rst_i) begin
        q_q <= SRVAL;
      end else begin
        q_q <= d_i;
      end
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/ramb_sp_param.sv
// Parametrised single-port synchronous block RAM with per-lane write enables,
// selectable write mode and an optional output register.
module ramb_sp_param
  import ramb_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 4,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           LANE_WIDTH = 4,
  parameter int unsigned           WRITE_MODE = 0,
  parameter int unsigned           DO_REG     = 0,
  parameter logic [DATA_WIDTH-1:0] SRVAL      = '0,
  parameter logic [DATA_WIDTH-1:0] INIT_WORD  = '0
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             EN,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] WE,
  input  logic [ADDR_WIDTH-1:0]            ADDR,
  input  logic [DATA_WIDTH-1:0]            DI,
  input  logic                             REGCE,
  output logic [DATA_WIDTH-1:0]            DO
);

  localparam int unsigned NumLanes = DATA_WIDTH / LANE_WIDTH;
  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_err_lane
    $error("DATA_WIDTH must be a multiple of LANE_WIDTH");
  end
  if (WRITE_MODE > 2) begin : g_err_mode
    $error("WRITE_MODE must be 0, 1 or 2");
  end
  if (DO_REG > 1) begin : g_err_doreg
    $error("DO_REG must be 0 or 1");
  end
  if (DATA_WIDTH > MaxWidth) begin : g_err_width
    $error("DATA_WIDTH exceeds lane_merge capacity");
  end

  logic [DATA_WIDTH-1:0] mem_q [Depth] = '{default: INIT_WORD};
  logic [DATA_WIDTH-1:0] dl_q = SRVAL;
  logic [DATA_WIDTH-1:0] dl_d;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  wr_any;

  always_comb begin
    wr_mask = '0;
    for (int unsigned i = 0; i < NumLanes; i++) begin
      wr_mask[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{WE[i]}};
    end
  end

  assign wr_any  = |WE;
  assign rd_word = mem_q[ADDR];
  assign wr_word = DATA_WIDTH'(lane_merge(MaxWidth'(rd_word), MaxWidth'(DI),
                                          MaxWidth'(wr_mask)));

  // Reset only touches the output stages, so writes proceed regardless of RST.
  always_ff @(posedge CLK) begin
    if (EN && wr_any) begin
      mem_q[ADDR] <= wr_word;
    end
  end

  always_comb begin
    dl_d = rd_word;
    if (wr_any) begin
      case (WRITE_MODE)
        WM_WRITE_FIRST: dl_d = wr_word;
        WM_READ_FIRST:  dl_d = rd_word;
        default:        dl_d = dl_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (EN) begin
      if (RST) begin
        dl_q <= SRVAL;
      end else begin
        dl_q <= dl_d;
      end
    end
  end

  if (DO_REG == 1) begin : g_oreg
    ramb_sp_oreg #(
      .DATA_WIDTH(DATA_WIDTH),
      .SRVAL     (SRVAL)
    ) u_oreg (
      .clk_i  (CLK),
      .rst_i  (RST),
      .regce_i(REGCE),
      .d_i    (dl_q),
      .q_o    (DO)
    );
  end else begin : g_no_oreg
    logic unused_regce;
    assign unused_regce = REGCE;
    assign DO           = dl_q;
  end

endmodule

// File: tb/tb_ramb_sp_param.sv
// Self-checking bench: eight RAM configurations share one stimulus stream and are
// compared every cycle against a word/lane-level reference model.
module tb_ramb_sp_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  we = '0;
  logic [9:0]  addr = '0;
  logic [15:0] di = '0;
  logic        regce = 1'b0;

  logic [15:0] do16 [6];
  logic [3:0]  do4a;
  logic [3:0]  do4b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Configs 0..5: 16-bit, 2 lanes, 16 words; mode = g%3, DO_REG = g/3.
  for (genvar g = 0; g < 6; g++) begin : g_w16
    ramb_sp_param #(
      .DATA_WIDTH(16),
      .ADDR_WIDTH(4),
      .LANE_WIDTH(8),
      .WRITE_MODE(g % 3),
      .DO_REG    (g / 3),
      .SRVAL     (16'hC3C3),
      .INIT_WORD (16'h5A5A)
    ) u_dut (
      .CLK  (clk),
      .RST  (rst),
      .EN   (en),
      .WE   (we),
      .ADDR (addr[3:0]),
      .DI   (di),
      .REGCE(regce),
      .DO   (do16[g])
    );
  end

  // Configs 6 and 7: default geometry (4x1024), WRITE_FIRST, DO_REG 0 and 1.
  ramb_sp_param #(
    .DATA_WIDTH(4),
    .ADDR_WIDTH(10),
    .LANE_WIDTH(4),
    .WRITE_MODE(0),
    .DO_REG    (0),
    .SRVAL     (4'hC),
    .INIT_WORD (4'h5)
  ) u_dut4a (
    .CLK  (clk),
    .RST  (rst),
    .EN   (en),
    .WE   (we[0:0]),
    .ADDR (addr),
    .DI   (di[3:0]),
    .REGCE(regce),
    .DO   (do4a)
  );

  ramb_sp_param #(
    .DATA_WIDTH(4),
    .ADDR_WIDTH(10),
    .LANE_WIDTH(4),
    .WRITE_MODE(0),
    .DO_REG    (1),
    .SRVAL     (4'hC),
    .INIT_WORD (4'h5)
  ) u_dut4b (
    .CLK  (clk),
    .RST  (rst),
    .EN   (en),
    .WE   (we[0:0]),
    .ADDR (addr),
    .DI   (di[3:0]),
    .REGCE(regce),
    .DO   (do4b)
  );

  function automatic int cfg_mode(input int k);
    return (k < 6) ? (k % 3) : 0;
  endfunction

  function automatic int cfg_doreg(input int k);
    return (k < 6) ? (k / 3) : (k - 6);
  endfunction

  function automatic logic [15:0] cfg_srval(input int k);
    return (k < 6) ? 16'hC3C3 : 16'h000C;
  endfunction

  function automatic logic [15:0] cfg_init(input int k);
    return (k < 6) ? 16'h5A5A : 16'h0005;
  endfunction

  function automatic logic [15:0] dut_do(input int k);
    if (k < 6) return do16[k];
    if (k == 6) return {12'h000, do4a};
    return {12'h000, do4b};
  endfunction

  // Reference model state.
  logic [15:0] m_mem [8][1024];
  logic [15:0] m_dl  [8];
  logic [15:0] m_dr  [8];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 8; k++) begin
      int          a;
      logic [15:0] old_w;
      logic [15:0] mask;
      logic [15:0] new_w;
      logic [15:0] dl_prev;
      a       = (k < 6) ? int'(addr[3:0]) : int'(addr);
      old_w   = m_mem[k][a];
      mask    = 16'h0000;
      if (k < 6) begin
        if (we[0]) mask[7:0] = 8'hFF;
        if (we[1]) mask[15:8] = 8'hFF;
      end else if (we[0]) begin
        mask = 16'h000F;
      end
      new_w   = (old_w & ~mask) | (di & mask);
      dl_prev = m_dl[k];
      if (regce) m_dr[k] = rst ? cfg_srval(k) : dl_prev;
      if (en) begin
        if (rst) m_dl[k] = cfg_srval(k);
        else if (mask == 16'h0000) m_dl[k] = old_w;
        else if (cfg_mode(k) == 0) m_dl[k] = new_w;
        else if (cfg_mode(k) == 1) m_dl[k] = old_w;
        if (mask != 16'h0000) m_mem[k][a] = new_w;
      end
    end
  endtask

  // One clock edge: advance the model, then compare every instance 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("model_do%0d", k), dut_do(k),
               (cfg_doreg(k) == 1) ? m_dr[k] : m_dl[k]);
    end
  endtask

  task automatic drive(input logic e, input logic r, input logic [1:0] w,
                       input logic [9:0] a, input logic [15:0] d, input logic rc);
    en    = e;
    rst   = r;
    we    = w;
    addr  = a;
    di    = d;
    regce = rc;
    step();
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 1024; j++) m_mem[k][j] = cfg_init(k);
      m_dl[k] = cfg_srval(k);
      m_dr[k] = cfg_srval(k);
    end

    #1;
    for (int k = 0; k < 8; k++) check_eq($sformatf("reset_do%0d", k), dut_do(k), cfg_srval(k));

    // Initial contents readable at both ends of the address space.
    drive(1'b1, 1'b0, 2'b00, 10'd0, 16'h0000, 1'b1);
    check_eq("init_addr0", dut_do(6), 16'h0005);
    drive(1'b1, 1'b0, 2'b00, 10'd1023, 16'h0000, 1'b1);
    check_eq("init_addr1023", dut_do(6), 16'h0005);

    // Partial-lane write under the three write modes.
    drive(1'b1, 1'b0, 2'b11, 10'd3, 16'hAAAA, 1'b1);
    drive(1'b1, 1'b0, 2'b11, 10'd5, 16'h0F0F, 1'b1);
    drive(1'b1, 1'b0, 2'b00, 10'd5, 16'h0000, 1'b1);
    drive(1'b1, 1'b0, 2'b01, 10'd3, 16'h1234, 1'b1);
    check_eq("wf_write_edge", dut_do(0), 16'hAA34);
    check_eq("rf_write_edge", dut_do(1), 16'hAAAA);
    check_eq("nc_write_edge", dut_do(2), 16'h0F0F);
    drive(1'b1, 1'b0, 2'b00, 10'd3, 16'h0000, 1'b1);
    check_eq("wf_readback", dut_do(0), 16'hAA34);
    check_eq("rf_readback", dut_do(1), 16'hAA34);
    check_eq("nc_readback", dut_do(2), 16'hAA34);
    check_eq("wf_oreg", dut_do(3), 16'hAA34);
    check_eq("rf_oreg", dut_do(4), 16'hAAAA);
    check_eq("nc_oreg", dut_do(5), 16'h0F0F);

    // Reset of the latch stage needs EN; writes still happen under reset.
    drive(1'b1, 1'b0, 2'b01, 10'd7, 16'h0007, 1'b1);
    check_eq("pre_rst_hold", dut_do(6), 16'h0007);
    drive(1'b0, 1'b1, 2'b01, 10'd7, 16'h0009, 1'b1);
    check_eq("rst_no_en", dut_do(6), 16'h0007);
    drive(1'b1, 1'b1, 2'b01, 10'd7, 16'h0009, 1'b1);
    check_eq("rst_with_en", dut_do(6), 16'h000C);
    drive(1'b1, 1'b0, 2'b00, 10'd7, 16'h0000, 1'b1);
    check_eq("write_under_rst", dut_do(6), 16'h0009);

    // Output register: two-edge latency, REGCE hold, REGCE-gated reset.
    drive(1'b1, 1'b0, 2'b01, 10'd2, 16'h0003, 1'b1);
    drive(1'b1, 1'b0, 2'b00, 10'd2, 16'h0000, 1'b1);
    check_eq("oreg_latency", dut_do(7), 16'h0003);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 2'b00, 10'(3 + 2 * i), 16'h0000, 1'b0);
      check_eq("oreg_hold", dut_do(7), 16'h0003);
    end
    drive(1'b0, 1'b1, 2'b00, 10'd0, 16'h0000, 1'b1);
    check_eq("oreg_rst", dut_do(7), 16'h000C);

    // Randomized traffic, checked every cycle against the model.
    for (int c = 0; c < 10000; c++) begin
      drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 19) == 0),
            2'($urandom_range(0, 3)), 10'($urandom), 16'($urandom),
            ($urandom_range(0, 9) < 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ramb_sp_param.md
Name: ramb_sp_param

Overview:
Parametrised single-port synchronous block RAM. It is the next-generation replacement for the fixed 1024x4 primitive wrappers in the unisims set.
- Generalises width and depth.
- Adds per-lane write enables, three selectable write modes and an optional pipelined output register.
- Sits in the same library layer. Higher-level memories and FIFOs instantiate it directly.

Parameters:
DATA_WIDTH, 4, data word width in bits; must be a multiple of LANE_WIDTH.
ADDR_WIDTH, 10, address width; depth = 2**ADDR_WIDTH words.
LANE_WIDTH, 4, bits per write-enable lane; WE width = DATA_WIDTH/LANE_WIDTH.
WRITE_MODE, 0, 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE.
DO_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.
SRVAL, 0, DATA_WIDTH-bit value loaded into the output stage(s) on reset.
INIT_WORD, 0, DATA_WIDTH-bit value every memory word holds at time zero.

Ports:
CLK  input  1  clock; all activity on the rising edge.
RST  input  1  synchronous, active-high reset of the output stage(s) only.
EN  input  1  port enable; gates read, write and latch-stage reset.
WE  input  DATA_WIDTH/LANE_WIDTH  per-lane write enable; lane i = DI[i*LANE_WIDTH +: LANE_WIDTH].
ADDR  input  ADDR_WIDTH  word address.
DI  input  DATA_WIDTH  write data.
REGCE  input  1  output-register clock enable; ignored when DO_REG=0.
DO  output  DATA_WIDTH  read data.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST). Nothing is asynchronous.
- Memory array:
  - Never cleared by RST.
  - Initialised to INIT_WORD at time zero.
  - Every address in 0..2**ADDR_WIDTH-1 is valid; no out-of-range case exists.
- Write:
  - At a rising edge with EN=1, each lane i with WE[i]=1 is written from DI to mem[ADDR].
  - Unselected lanes keep their old value.
  - RST does not block writes.
- Latch stage (dl):
  - Initial value SRVAL.
  - EN=0: dl holds, regardless of RST, WE and ADDR.
  - EN=1, RST=1: dl <= SRVAL. Any write in the same cycle still happens.
  - EN=1, RST=0, WE all zero: dl <= mem[ADDR].
  - EN=1, RST=0, WE nonzero, by mode:
    - WRITE_FIRST: dl gets the new data in written lanes and old mem data in unwritten lanes.
    - READ_FIRST: dl <= old mem[ADDR] (pre-write).
    - NO_CHANGE: dl holds.
- Output register (dr), present only when DO_REG=1:
  - Initial value SRVAL.
  - RST=1 and REGCE=1: dr <= SRVAL.
  - RST=0 and REGCE=1: dr <= dl.
  - REGCE=0: dr holds, RST included.
  - dr reset is independent of EN.
- DO = dl when DO_REG=0, dr when DO_REG=1.
- Latency:
  - DO_REG=0: read data visible one edge after address/EN.
  - DO_REG=1: two edges, with REGCE=1 on the second.
- Reset mid-read, DO_REG=1: reset clears only the stage(s) it reaches. dl reset needs EN=1; dr reset needs REGCE=1. A read in flight in dl still reaches DO on the next REGCE edge unless EN=1 and RST=1 cleared dl first.
- Back-to-back writes to the same address: the last write wins. A read of that address in the following cycle returns it (no hazard).
- Elaboration errors (reported via generate-time $error):
  - DATA_WIDTH % LANE_WIDTH != 0
  - WRITE_MODE > 2
  - DO_REG > 1

Decomposition:
- Shared package ramb_pkg:
  - write-mode constants WM_WRITE_FIRST=0, WM_READ_FIRST=1, WM_NO_CHANGE=2.
  - function for lane-merge of old/new data.
- One sub-module, ramb_sp_oreg: the optional DO_REG output register with REGCE and RST→SRVAL. Instantiated under generate when DO_REG=1.
- Array, write logic and latch stage stay in the top.

Test Plan:
1. Default params, INIT_WORD=4'h5. Read ADDR=0 and ADDR=1023 with EN=1, WE=0 -> DO=4'h5 one edge later, each.
2. DATA_WIDTH=16, LANE_WIDTH=8, WRITE_FIRST. mem[3]=16'hAAAA; write WE=2'b01, DI=16'h1234 -> DO=16'hAA34 same edge; next read gives 16'hAA34.
3. Same setup, READ_FIRST -> DO=16'hAAAA on write edge. NO_CHANGE: DO keeps its prior value 16'h0F0F on the write edge, then 16'hAA34 on a following read.
4. SRVAL=4'hC, DO holding 4'h7. RST=1, EN=0 -> DO stays 4'h7. RST=1, EN=1, WE=1, DI=4'h9 -> DO=4'hC and mem[ADDR]=4'h9.
5. DO_REG=1. Read mem[2]=4'h3 with REGCE=1 -> DO=4'h3 after the second edge. Hold REGCE=0 for 3 cycles while reading other data -> DO stays 4'h3. RST=1, REGCE=1 -> DO=SRVAL.
6. Random writes/reads over 10k cycles, all modes and DO_REG values -> DO matches the reference-model scoreboard every cycle.
